// File: rtl/alu_mc_if.sv
// Request/result bus of the multi-cycle ALU.
//
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both high; opcode and operands are sampled on that edge
// only. A result transfers on a rising edge where out_valid and out_ready
// are both high; out/zero are held stable while out_valid is high and
// out_ready is low. in_ready never depends combinationally on in_valid, and
// out_valid never depends on out_ready.
interface alu_mc_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALU_Operation;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             busy;
    logic [1:0]       dbg_state;

    // Requester / result consumer side.
    modport master (
        output in_valid,
        output ALU_Operation,
        output rd1,
        output rd2,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  zero,
        input  busy,
        input  dbg_state
    );

    // ALU side.
    modport slave (
        input  in_valid,
        input  ALU_Operation,
        input  rd1,
        input  rd2,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output zero,
        output busy,
        output dbg_state
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU between register-file read and writeback.
// Single-cycle ops (logic, add/sub, shifts, compares, divide-by-zero) finish
// one edge after accept. MUL/MULHU run a shift-add multiply and DIVU/REMU a
// restoring divide, one bit per cycle for WIDTH cycles, both on one shared
// 2*WIDTH register. The result is held in DONE until the consumer takes it.
module alu_mc #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     n_rst,
    alu_mc_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               hi_sel;     // MULHU / REMU: take the upper half
    logic [WIDTH-1:0]   a_q;        // latched multiplicand
    logic [WIDTH-1:0]   b_q;        // latched divisor
    logic [2*WIDTH-1:0] prod;       // {acc, multiplier} or {remainder, quotient}
    logic [WIDTH-1:0]   out_q;
    logic               zero_q;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   quick;
    logic               is_mul;
    logic               is_div;
    logic               div_zero;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   mul_sel;

    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_sel;

    assign shamt    = bus.rd2[SHAMT_W-1:0];
    assign is_mul   = (bus.ALU_Operation[3:1] == 3'b101);
    assign is_div   = (bus.ALU_Operation[3:1] == 3'b110);
    assign div_zero = (bus.rd2 == '0);

    // Result of every op that completes on the accept edge. DIVU/REMU rows
    // only matter for a zero divisor; MUL/MULHU and 1110/1111 give 0 here.
    always_comb begin
        quick = '0;
        case (bus.ALU_Operation)
            OP_AND:  quick = bus.rd1 & bus.rd2;
            OP_OR:   quick = bus.rd1 | bus.rd2;
            OP_ADD:  quick = bus.rd1 + bus.rd2;
            OP_SUB:  quick = bus.rd1 - bus.rd2;
            OP_XOR:  quick = bus.rd1 ^ bus.rd2;
            OP_SLL:  quick = bus.rd1 << shamt;
            OP_SRL:  quick = bus.rd1 >> shamt;
            OP_SRA:  quick = $unsigned($signed(bus.rd1) >>> shamt);
            OP_SLT:  quick = {{(WIDTH-1){1'b0}}, ($signed(bus.rd1) < $signed(bus.rd2))};
            OP_SLTU: quick = {{(WIDTH-1){1'b0}}, (bus.rd1 < bus.rd2)};
            OP_DIVU: quick = '1;
            OP_REMU: quick = bus.rd1;
            default: quick = '0;
        endcase
    end

    // One shift-add multiply step: add the multiplicand into the upper half
    // when the current multiplier bit is set, then shift the pair right.
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, prod[WIDTH-1:1]};
        mul_sel  = hi_sel ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
    end

    // One restoring-divide step. The remainder stays below the divisor, so
    // the shifted value is below twice the divisor and the borrow bit of the
    // WIDTH+1 subtraction is an exact "shifted < divisor" flag.
    always_comb begin
        div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[WIDTH];
        div_next  = div_ge ? {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        div_sel   = hi_sel ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
    end

    // Control FSM plus datapath registers; reset aborts any operation.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi_sel <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            prod   <= '0;
            out_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.rd1;
                        b_q    <= bus.rd2;
                        hi_sel <= bus.ALU_Operation[0];
                        cnt    <= '0;
                        if (is_mul) begin
                            prod  <= {{WIDTH{1'b0}}, bus.rd2};
                            state <= S_MUL;
                        end else if (is_div && !div_zero) begin
                            prod  <= {{WIDTH{1'b0}}, bus.rd1};
                            state <= S_DIV;
                        end else begin
                            out_q  <= quick;
                            zero_q <= (quick == '0);
                            state  <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        out_q  <= mul_sel;
                        zero_q <= (mul_sel == '0);
                        state  <= S_DONE;
                    end
                end
                S_DIV: begin
                    prod <= div_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        out_q  <= div_sel;
                        zero_q <= (div_sel == '0);
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomized bench for alu_mc against an arithmetic reference.
module tb_alu_mc;

    localparam int WIDTH = 32;
    localparam int LAT_LONG = WIDTH + 1;

    logic clk = 1'b0;
    logic n_rst;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    alu_mc_if #(.WIDTH(WIDTH)) bus ();

    alu_mc #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what each opcode means, in plain arithmetic.
    function automatic logic [WIDTH-1:0] model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [63:0] p;
        logic signed [WIDTH-1:0] sa;
        int s;
        p  = 64'(a) * 64'(b);
        sa = a;
        s  = int'(b[4:0]);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return a << s;
            4'd5:  return a >> s;
            4'd6:  return a - b;
            4'd7:  return sa >>> s;
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [WIDTH-1:0] b);
        if (op == 4'd10 || op == 4'd11) return LAT_LONG;
        if ((op == 4'd12 || op == 4'd13) && b != 0) return LAT_LONG;
        return 1;
    endfunction

    // Driver: issue one op, measure latency, check result, hold, then release.
    task automatic run_op(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int hold, input bit noisy, input string tag);
        int lat;
        bit leak;
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] held;
        e = model(op, a, b);
        exp_q.push_back(e);
        @(negedge clk);
        chk({tag, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.ALU_Operation = op;
        bus.rd1 = a;
        bus.rd2 = b;
        @(posedge clk);
        #1;
        if (!noisy) bus.in_valid = 1'b0;
        lat = 0;
        leak = 1'b0;
        do begin
            bus.rd1 = $urandom;
            bus.rd2 = $urandom;
            bus.ALU_Operation = 4'($urandom_range(0, 15));
            @(negedge clk);
            lat++;
            if (!bus.out_valid && bus.in_ready) leak = 1'b1;
        end while (!bus.out_valid && lat < 200);
        bus.in_valid = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(model_lat(op, b)));
        chk({tag, " out"}, bus.out, exp_q.pop_front());
        chk({tag, " zero"}, 32'(bus.zero), 32'(e == 0));
        chk({tag, " busy_done"}, 32'(bus.busy), 32'd1);
        chk({tag, " in_ready_done"}, 32'(bus.in_ready), 32'd0);
        chk({tag, " ready_while_busy"}, 32'(leak), 32'd0);
        held = bus.out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold_out"}, bus.out, held);
            chk({tag, " hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, " hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, " valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " idle_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, " out_kept"}, bus.out, held);
    endtask

    initial begin
        logic [3:0] rop;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        // Reset
        n_rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.ALU_Operation = 4'd0;
        bus.rd1 = '0;
        bus.rd2 = '0;
        repeat (3) @(negedge clk);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out", bus.out, 32'd0);
        chk("rst zero", 32'(bus.zero), 32'd1);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        n_rst = 1'b1;

        // Directed single-cycle ops
        run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "add_wrap");
        run_op(4'b0110, 32'd5, 32'd7, 0, 1'b0, "sub_wrap");
        run_op(4'b0111, 32'h8000_0000, 32'h24, 0, 1'b0, "sra");
        run_op(4'b1000, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "slt");
        run_op(4'b1001, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "sltu");
        run_op(4'b1110, 32'h1234, 32'h5678, 0, 1'b0, "undef");

        // Iterative ops, with request-side noise during iteration
        run_op(4'b1010, 32'h0001_0000, 32'h0001_0000, 0, 1'b1, "mul");
        run_op(4'b1011, 32'h0001_0000, 32'h0001_0000, 0, 1'b1, "mulhu");
        run_op(4'b1100, 32'd100, 32'd7, 0, 1'b0, "divu");
        run_op(4'b1101, 32'd100, 32'd7, 0, 1'b0, "remu");
        run_op(4'b1100, 32'd9, 32'd0, 0, 1'b0, "divu_by0");
        run_op(4'b1101, 32'd9, 32'd0, 0, 1'b0, "remu_by0");

        // Output backpressure
        run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5, 1'b0, "hold5");

        // Request presented in DONE alongside out_ready is taken only in IDLE
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ALU_Operation = 4'b0010;
        bus.rd1 = 32'd1;
        bus.rd2 = 32'd2;
        @(posedge clk);
        #1;
        bus.ALU_Operation = 4'b0011;
        bus.rd1 = 32'hF0;
        bus.rd2 = 32'h0F;
        @(negedge clk);
        chk("b2b first_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b first_out", bus.out, 32'd3);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("b2b not_in_done", 32'(bus.out_valid), 32'd0);
        chk("b2b idle_ready", 32'(bus.in_ready), 32'd1);
        chk("b2b out_kept", bus.out, 32'd3);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b second_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b second_out", bus.out, 32'hFF);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset in the middle of a divide
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ALU_Operation = 4'b1100;
        bus.rd1 = 32'd100;
        bus.rd2 = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort busy_before", 32'(bus.busy), 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("abort out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort out", bus.out, 32'd0);
        chk("abort zero", 32'(bus.zero), 32'd1);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        n_rst = 1'b1;
        run_op(4'b0010, 32'd40, 32'd2, 0, 1'b0, "add_after_rst");

        // Randomized ops against the reference
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = '0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
            run_op(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
        end

        // Report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
